mips_pipe_ctrl: RTL and testbench

//  Parametrised pipeline sequencer for the pipelined MIPS datapath: tracks per-stage valid/dest/write info,

---
 rtl/mips_pipe_ctrl_pkg.sv | 27 ++
 rtl/mips_pipe_ctrl_hazard_cmp.sv | 21 ++
 rtl/mips_pipe_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_mips_pipe_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_ctrl_pkg.sv
// Shared definitions for the MIPS pipeline sequencer.
//  - stage indices for the fixed front of the pipe (IF, ID, EX, MEM)
//  - operand-select encodings driven on fwd_a / fwd_b
//  - low_mask(): helper used to build per-stage flush masks
package mips_pipe_ctrl_pkg;

   localparam int ST_IF  = 0;
   localparam int ST_ID  = 1;
   localparam int ST_EX  = 2;
   localparam int ST_MEM = 3;

   localparam int MAX_DEPTH = 8;

   localparam logic [1:0] FWD_RF  = 2'd0;
   localparam logic [1:0] FWD_MEM = 2'd1;
   localparam logic [1:0] FWD_WB  = 2'd2;

   // Bits [n-1:0] set, the rest clear.
   function automatic logic [MAX_DEPTH-1:0] low_mask(input int n);
      logic [MAX_DEPTH-1:0] m;
      for (int i = 0; i < MAX_DEPTH; i++) begin
         m[i] = (i < n);
      end
      return m;
   endfunction

endpackage

// File: rtl/mips_pipe_ctrl_hazard_cmp.sv
// One producer-vs-source RAW match.
// Ports:
//  prod_valid, prod_reg_write, prod_dest : producer stage info
//  src, src_use                          : consumer source register and its use bit
//  hit                                   : producer will write the register the consumer reads
// Register 0 is hard-wired to zero, so it never produces a match.
module mips_pipe_ctrl_hazard_cmp #(
   parameter int AW = 5
) (
   input  logic          prod_valid,
   input  logic          prod_reg_write,
   input  logic [AW-1:0] prod_dest,
   input  logic [AW-1:0] src,
   input  logic          src_use,
   output logic          hit
);

   assign hit = prod_valid & prod_reg_write & (prod_dest != '0) &
                (prod_dest == src) & src_use;

endmodule

// File: rtl/mips_pipe_ctrl.sv
// Pipeline sequencer for the pipelined MIPS datapath. Tracks valid/dest/write
// info for every stage from EX to WB, detects RAW hazards against the ID
// instruction, and drives PC / IF-ID enables, per-register flushes and the EX
// operand selects.
// Build option: MIPS_PIPE_FWD_EN
//  defined   : EX/MEM and MEM/WB forwarding, only load-use stalls the ID stage
//  undefined : no forwarding (fwd_* held at 0), ID interlocks on any in-flight
//              producer up to and including WB
// Ports:
//  clk, rst                 clock, synchronous active-high reset
//  id_rs/id_rt/id_use_*     ID source registers and use bits
//  id_dest/id_reg_write     ID destination and write enable
//  id_mem_read              ID instruction is a load
//  redirect                 taken branch / jump resolved in RESOLVE_STAGE
//  ext_stall                freeze whole pipe
//  pc_en, ifid_en           PC and IF/ID register enables
//  flush[i]                 synchronous clear of the register after stage i
//  stage_valid[i]           stage i holds a live instruction
//  fwd_a, fwd_b             EX operand selects (registered)
//  stall_cnt                saturating count of cycles with pc_en low
module mips_pipe_ctrl
   import mips_pipe_ctrl_pkg::*;
#(
   parameter int DEPTH         = 5,
   parameter int REG_AW        = 5,
   parameter int RESOLVE_STAGE = 3,
   parameter int CNT_W         = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic [REG_AW-1:0] id_dest,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              redirect,
   input  logic              ext_stall,
   output logic              pc_en,
   output logic              ifid_en,
   output logic [DEPTH-1:0]  flush,
   output logic [DEPTH-1:0]  stage_valid,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [DEPTH-1:0] FLUSH_MASK = DEPTH'(low_mask(RESOLVE_STAGE));
   // Stages 0..RESOLVE_STAGE lose their contents on a redirect; IF is refetching.
   localparam logic [DEPTH-1:0] VALID_CLR  = {FLUSH_MASK[DEPTH-2:0], 1'b1};

   logic [DEPTH-1:0]     valid_q, valid_d;
   logic [REG_AW-1:0]    dest_q [ST_EX:DEPTH-1];
   logic [REG_AW-1:0]    dest_d [ST_EX:DEPTH-1];
   logic [DEPTH-1:ST_EX] rw_q, rw_d;
   logic                 ex_mr_q, ex_mr_d;
   logic                 pend_q, pend_d;
   logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
`ifdef MIPS_PIPE_FWD_EN
   logic [1:0]           fwd_a_q, fwd_a_d;
   logic [1:0]           fwd_b_q, fwd_b_d;
`endif

   logic [DEPTH-1:ST_EX] hit_rs, hit_rt;
   logic                 redir, load_use, interlock, hazard;

   for (genvar s = ST_EX; s < DEPTH; s++) begin : g_cmp
      mips_pipe_ctrl_hazard_cmp #(.AW(REG_AW)) u_cmp_rs (
         .prod_valid     (valid_q[s]),
         .prod_reg_write (rw_q[s]),
         .prod_dest      (dest_q[s]),
         .src            (id_rs),
         .src_use        (id_use_rs),
         .hit            (hit_rs[s])
      );
      mips_pipe_ctrl_hazard_cmp #(.AW(REG_AW)) u_cmp_rt (
         .prod_valid     (valid_q[s]),
         .prod_reg_write (rw_q[s]),
         .prod_dest      (dest_q[s]),
         .src            (id_rt),
         .src_use        (id_use_rt),
         .hit            (hit_rt[s])
      );
   end

   always_comb begin
      redir    = !ext_stall && (redirect || pend_q);
      load_use = (hit_rs[ST_EX] || hit_rt[ST_EX]) && ex_mr_q;
`ifdef MIPS_PIPE_FWD_EN
      // Stages between MEM and WB (DEPTH > 5) have no forwarding path.
      interlock = load_use;
      for (int s = ST_MEM; s <= DEPTH-3; s++) begin
         interlock = interlock || hit_rs[s] || hit_rt[s];
      end
`else
      interlock = load_use || (|hit_rs) || (|hit_rt);
`endif
      // A redirect kills the ID instruction, so its hazard is moot.
      hazard  = valid_q[ST_ID] && !redir && interlock;
      pc_en   = !ext_stall && !hazard;
      ifid_en = pc_en;
      flush   = redir ? FLUSH_MASK : '0;

      valid_d     = valid_q;
      dest_d      = dest_q;
      rw_d        = rw_q;
      ex_mr_d     = ex_mr_q;
      pend_d      = pend_q;
      stall_cnt_d = stall_cnt_q;
`ifdef MIPS_PIPE_FWD_EN
      fwd_a_d     = fwd_a_q;
      fwd_b_d     = fwd_b_q;
`endif

      if (!pc_en && !(&stall_cnt_q)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end

      if (ext_stall) begin
         pend_d = pend_q || redirect;
      end else begin
         pend_d = 1'b0;
         for (int s = DEPTH-1; s > ST_EX; s--) begin
            valid_d[s] = valid_q[s-1];
            dest_d[s]  = dest_q[s-1];
            rw_d[s]    = rw_q[s-1];
         end
         valid_d[ST_EX] = valid_q[ST_ID] && !hazard;
         dest_d[ST_EX]  = id_dest;
         rw_d[ST_EX]    = id_reg_write;
         ex_mr_d        = id_mem_read;
         valid_d[ST_ID] = hazard ? valid_q[ST_ID] : valid_q[ST_IF];
         valid_d[ST_IF] = 1'b1;
         if (redir) begin
            valid_d = valid_d & ~VALID_CLR;
         end
`ifdef MIPS_PIPE_FWD_EN
         // Selects describe where the producer sits once ID has moved to EX.
         if (hazard || redir) begin
            fwd_a_d = FWD_RF;
            fwd_b_d = FWD_RF;
         end else begin
            fwd_a_d = hit_rs[ST_EX] ? FWD_MEM : (hit_rs[DEPTH-2] ? FWD_WB : FWD_RF);
            fwd_b_d = hit_rt[ST_EX] ? FWD_MEM : (hit_rt[DEPTH-2] ? FWD_WB : FWD_RF);
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q     <= '0;
         rw_q        <= '0;
         ex_mr_q     <= 1'b0;
         pend_q      <= 1'b0;
         stall_cnt_q <= '0;
         for (int s = ST_EX; s < DEPTH; s++) begin
            dest_q[s] <= '0;
         end
`ifdef MIPS_PIPE_FWD_EN
         fwd_a_q     <= FWD_RF;
         fwd_b_q     <= FWD_RF;
`endif
      end else begin
         valid_q     <= valid_d;
         dest_q      <= dest_d;
         rw_q        <= rw_d;
         ex_mr_q     <= ex_mr_d;
         pend_q      <= pend_d;
         stall_cnt_q <= stall_cnt_d;
`ifdef MIPS_PIPE_FWD_EN
         fwd_a_q     <= fwd_a_d;
         fwd_b_q     <= fwd_b_d;
`endif
      end
   end

   assign stage_valid = valid_q;
   assign stall_cnt   = stall_cnt_q;
`ifdef MIPS_PIPE_FWD_EN
   assign fwd_a = fwd_a_q;
   assign fwd_b = fwd_b_q;
`else
   assign fwd_a = FWD_RF;
   assign fwd_b = FWD_RF;
`endif

endmodule

// File: tb/tb_mips_pipe_ctrl.sv
// Directed bench for mips_pipe_ctrl (DEPTH=5, RESOLVE_STAGE=3, CNT_W=4 so
// that saturation is reachable). Expected values are hand-derived for the
// build selected by MIPS_PIPE_FWD_EN.
module tb_mips_pipe_ctrl;

`ifdef MIPS_PIPE_FWD_EN
   localparam int BASE = 1;
`else
   localparam int BASE = 3;
`endif

   logic       clk;
   logic       rst;
   logic [4:0] id_rs, id_rt, id_dest;
   logic       id_use_rs, id_use_rt, id_reg_write, id_mem_read;
   logic       redirect, ext_stall;
   logic       pc_en, ifid_en;
   logic [4:0] flush, stage_valid;
   logic [1:0] fwd_a, fwd_b;
   logic [3:0] stall_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   mips_pipe_ctrl #(
      .DEPTH(5), .REG_AW(5), .RESOLVE_STAGE(3), .CNT_W(4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_use_rs    (id_use_rs),
      .id_use_rt    (id_use_rt),
      .id_dest      (id_dest),
      .id_reg_write (id_reg_write),
      .id_mem_read  (id_mem_read),
      .redirect     (redirect),
      .ext_stall    (ext_stall),
      .pc_en        (pc_en),
      .ifid_en      (ifid_en),
      .flush        (flush),
      .stage_valid  (stage_valid),
      .fwd_a        (fwd_a),
      .fwd_b        (fwd_b),
      .stall_cnt    (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                        input logic urt, input logic [4:0] dest, input logic rw,
                        input logic mr, input logic rd, input logic xs);
      id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
      id_dest = dest; id_reg_write = rw; id_mem_read = mr;
      redirect = rd; ext_stall = xs;
      #1;
   endtask

   task automatic nop();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      nop();
      tick();
      tick();
      chk("rst_valid",   stage_valid, 32'h0);
      chk("rst_flush",   flush,       32'h0);
      chk("rst_pc_en",   pc_en,       32'h1);
      chk("rst_ifid_en", ifid_en,     32'h1);
      chk("rst_cnt",     stall_cnt,   32'h0);
      chk("rst_fwd_a",   fwd_a,       32'h0);
      chk("rst_fwd_b",   fwd_b,       32'h0);
      rst = 1'b0;
      repeat (5) tick();
      chk("fill_valid", stage_valid, 32'h1f);

`ifdef MIPS_PIPE_FWD_EN
      // add $3,$1,$2 ; sub $4,$3,$5
      drive(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("add_pc_en", pc_en, 32'h1);
      tick();
      drive(5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("sub_no_stall", pc_en, 32'h1);
      tick();
      nop();
      chk("sub_fwd_a", fwd_a, 32'h1);
      chk("sub_fwd_b", fwd_b, 32'h0);
      // add $3 ; nop ; or $6,$3,$3
      drive(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      nop();
      tick();
      drive(5'd3, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("or_pc_en", pc_en, 32'h1);
      tick();
      nop();
      chk("or_fwd_a", fwd_a, 32'h2);
      chk("or_fwd_b", fwd_b, 32'h2);
      // lw $3,0($1) ; add $4,$3,$3
      drive(5'd1, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      drive(5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("lu_stall", pc_en, 32'h0);
      tick();
      chk("lu_bubble", stage_valid[2], 32'h0);
      chk("lu_release", pc_en, 32'h1);
      tick();
      nop();
      chk("lu_fwd_a", fwd_a, 32'h2);
      chk("lu_fwd_b", fwd_b, 32'h2);
      chk("lu_cnt", stall_cnt, 32'h1);
      // load-use coincident with redirect
      drive(5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      drive(5'd8, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("lu_redir_pc_en", pc_en, 32'h1);
      chk("lu_redir_flush", flush, 32'h07);
      tick();
      nop();
      chk("lu_redir_cnt", stall_cnt, 32'h1);
`else
      // add $3,$1,$2 ; sub $4,$3,$5 -> 3-cycle interlock
      drive(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("add_pc_en", pc_en, 32'h1);
      tick();
      drive(5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("raw_stall1", pc_en, 32'h0);
      chk("raw_stall1_ifid", ifid_en, 32'h0);
      tick();
      chk("raw_stall2", pc_en, 32'h0);
      chk("raw_bubble", stage_valid[2], 32'h0);
      tick();
      chk("raw_stall3", pc_en, 32'h0);
      tick();
      chk("raw_release", pc_en, 32'h1);
      chk("raw_cnt", stall_cnt, 32'h3);
      chk("raw_fwd_a", fwd_a, 32'h0);
      tick();
      nop();
      chk("sub_in_ex", stage_valid[2], 32'h1);
      chk("sub_fwd_b", fwd_b, 32'h0);
`endif

      // writes to $0 never create a dependency
      drive(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("r0_no_stall", pc_en, 32'h1);
      tick();
      nop();

      // taken branch with a dependent ID instruction
      drive(5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      drive(5'd7, 5'd7, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("br_flush", flush, 32'h07);
      chk("br_pc_en", pc_en, 32'h1);
      tick();
      nop();
      chk("br_valid", stage_valid[3:0], 32'h0);
      chk("br_flush_off", flush, 32'h0);
      chk("br_cnt", stall_cnt, BASE);
      repeat (5) tick();

      // ext_stall for 4 cycles, redirect pulsed in the 2nd
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("xs_pc_en", pc_en, 32'h0);
      chk("xs_ifid_en", ifid_en, 32'h0);
      tick();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("xs_flush_held", flush, 32'h0);
      tick();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      tick();
      nop();
      chk("xs_pend_flush", flush, 32'h07);
      chk("xs_pc_en_back", pc_en, 32'h1);
      chk("xs_cnt", stall_cnt, BASE + 4);
      chk("xs_frozen", stage_valid, 32'h1f);
      tick();
      chk("xs_after_valid", stage_valid, 32'h10);
      chk("xs_after_flush", flush, 32'h0);
      repeat (5) tick();

      // reset in the middle of a load-use stall
      drive(5'd1, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      drive(5'd9, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("mid_stall", pc_en, 32'h0);
      rst = 1'b1;
      tick();
      chk("mid_rst_valid", stage_valid, 32'h0);
      chk("mid_rst_cnt", stall_cnt, 32'h0);
      chk("mid_rst_pc_en", pc_en, 32'h1);
      rst = 1'b0;

      // counter saturates at all-ones
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (20) tick();
      chk("cnt_sat", stall_cnt, 32'hf);
      chk("sat_frozen", stage_valid, 32'h0);
      nop();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
